// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter
//   Round-robin arbiter that shares the single write port of the async FIFO
//   among NUM_REQ requesters. Lives entirely in the write-clock domain.
//   Each grant covers a burst of up to BURST_LEN words. A burst ends early
//   when the granted requester drops req. Writes stall, and data is never
//   lost, while fifo_full is high. IDLE is always visited between two grants.
//
// Optional feature (macro FIFO_ARB_TIMEOUT_EN):
//   A stall counter forces re-arbitration after TIMEOUT_CYCLES consecutive
//   full-stalled cycles. Without the macro, a full stall holds the grant
//   indefinitely.
//
// Ports:
//   clk         write-domain clock (same as FIFO wr_clk)
//   rst         asynchronous, active-low reset
//   req         per-requester write request; held with stable data until acked
//   data_in     packed request data, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   fifo_full   FIFO full flag (clk domain)
//   ack         one-hot; ack[i]=1 in the cycle requester i's word is written
//   fifo_wr_req FIFO write strobe
//   fifo_data   word presented to FIFO data_in
//   grant_id    currently / last granted requester
//   busy        high while a grant is active (XFER)
module fifo_write_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int DATA_WIDTH     = 1,
  parameter int BURST_LEN      = 4,
  parameter int TIMEOUT_CYCLES = 8,
  localparam int GW            = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] data_in,
  input  logic                          fifo_full,
  output logic [NUM_REQ-1:0]            ack,
  output logic                          fifo_wr_req,
  output logic [DATA_WIDTH-1:0]         fifo_data,
  output logic [GW-1:0]                 grant_id,
  output logic                          busy
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_XFER = 1'b1
  } state_t;

  localparam logic [3:0]    BURST_C = 4'(BURST_LEN);
  localparam logic [GW-1:0] LAST_RST = GW'(NUM_REQ - 1);

  state_t        state_q, state_d;
  logic [GW-1:0] grant_id_q, grant_id_d;
  logic [GW-1:0] last_grant_q, last_grant_d;
  logic [3:0]    count_q, count_d;
  logic          sel_req_s;
  logic          wr_s;

`ifdef FIFO_ARB_TIMEOUT_EN
  localparam int          SW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [SW-1:0] TIMEOUT_C = SW'(TIMEOUT_CYCLES);
  logic [SW-1:0] stall_q, stall_d;
`endif

  // First set request bit strictly after 'last', wrapping modulo NUM_REQ.
  function automatic logic [GW-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                            input logic [GW-1:0]      last);
    logic [GW-1:0] pick;
    logic [GW-1:0] idx;
    logic          found;
    pick  = '0;
    found = 1'b0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      idx = GW'((int'(last) + off) % NUM_REQ);
      if (!found && r[idx]) begin
        pick  = idx;
        found = 1'b1;
      end else begin
        found = found;
      end
    end
    return pick;
  endfunction

  // Write handshake: combinational so the write lands in the same cycle req/full allow it.
  always_comb begin
    sel_req_s = req[grant_id_q];
    wr_s      = (state_q == S_XFER) & sel_req_s & ~fifo_full;
    ack       = '0;
    ack[grant_id_q] = wr_s;
  end

  assign fifo_wr_req = wr_s;
  assign grant_id    = grant_id_q;
  assign busy        = (state_q == S_XFER);
  // Forced to zero while reset is held; otherwise the granted slice in every state.
  assign fifo_data   = rst ? data_in[grant_id_q*DATA_WIDTH +: DATA_WIDTH] : '0;

  // Next-state logic: arbitration in IDLE, beat counting and exits in XFER.
  always_comb begin
    state_d      = state_q;
    grant_id_d   = grant_id_q;
    last_grant_d = last_grant_q;
    count_d      = count_q;
`ifdef FIFO_ARB_TIMEOUT_EN
    stall_d      = '0;
`endif
    case (state_q)
      S_IDLE: begin
        if (|req) begin
          grant_id_d = rr_pick(req, last_grant_q);
          count_d    = 4'd0;
          state_d    = S_XFER;
        end else begin
          state_d    = S_IDLE;
        end
      end
      S_XFER: begin
        if (wr_s) begin
          count_d = count_q + 4'd1;
          if (count_d == BURST_C) begin
            state_d      = S_IDLE;
            last_grant_d = grant_id_q;
          end else begin
            state_d      = S_XFER;
          end
        end else if (!sel_req_s) begin
          // Requester withdrew: a partial burst is legal.
          state_d      = S_IDLE;
          last_grant_d = grant_id_q;
        end else begin
          // Full stall: hold grant and count.
`ifdef FIFO_ARB_TIMEOUT_EN
          stall_d = stall_q + {{(SW-1){1'b0}}, 1'b1};
          if (stall_d == TIMEOUT_C) begin
            state_d      = S_IDLE;
            last_grant_d = grant_id_q;
            stall_d      = '0;
          end else begin
            state_d      = S_XFER;
          end
`else
          state_d = S_XFER;
`endif
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      grant_id_q   <= '0;
      last_grant_q <= LAST_RST;
      count_q      <= 4'd0;
`ifdef FIFO_ARB_TIMEOUT_EN
      stall_q      <= '0;
`endif
    end else begin
      state_q      <= state_d;
      grant_id_q   <= grant_id_d;
      last_grant_q <= last_grant_d;
      count_q      <= count_d;
`ifdef FIFO_ARB_TIMEOUT_EN
      stall_q      <= stall_d;
`endif
    end
  end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Testbench for fifo_write_arbiter: a behavioural model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_fifo_write_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int BL = 4;
  localparam int TO = 8;

  logic            clk;
  logic            rst;
  logic [N-1:0]    req;
  logic [N*DW-1:0] data_in;
  logic            fifo_full;
  logic [N-1:0]    ack;
  logic            fifo_wr_req;
  logic [DW-1:0]   fifo_data;
  logic [1:0]      grant_id;
  logic            busy;

  int total = 0;
  int bad   = 0;

  fifo_write_arbiter #(
    .NUM_REQ(N), .DATA_WIDTH(DW), .BURST_LEN(BL), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .data_in(data_in), .fifo_full(fifo_full),
    .ack(ack), .fifo_wr_req(fifo_wr_req), .fifo_data(fifo_data),
    .grant_id(grant_id), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Who owns the port, how many words it has written in this grant, and who
  // was served last; updated once per clock from the spec's rules.
  bit m_busy;
  int m_gid, m_last, m_beats, m_stall;

  always @(posedge clk) begin
    if (!rst) begin
      m_busy = 1'b0; m_gid = 0; m_last = N - 1; m_beats = 0; m_stall = 0;
    end else if (!m_busy) begin
      if (req != '0) begin
        for (int k = 1; k <= N; k++) begin
          if (req[(m_last + k) % N]) begin
            m_gid = (m_last + k) % N;
            break;
          end
        end
        m_busy = 1'b1; m_beats = 0; m_stall = 0;
      end
    end else begin
      if (req[m_gid] && !fifo_full) begin
        m_beats++;
        m_stall = 0;
        if (m_beats == BL) begin m_busy = 1'b0; m_last = m_gid; end
      end else if (!req[m_gid]) begin
        m_busy = 1'b0; m_last = m_gid;
      end else begin
`ifdef FIFO_ARB_TIMEOUT_EN
        m_stall++;
        if (m_stall == TO) begin m_busy = 1'b0; m_last = m_gid; m_stall = 0; end
`endif
      end
    end
  end

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    logic       e_wr;
    logic [N-1:0] e_ack;
    if (!rst) begin
      chk("rst_wr",   {31'd0, fifo_wr_req}, 32'd0);
      chk("rst_ack",  {28'd0, ack},         32'd0);
      chk("rst_busy", {31'd0, busy},        32'd0);
      chk("rst_data", {24'd0, fifo_data},   32'd0);
    end else begin
      e_wr  = m_busy && req[m_gid] && !fifo_full;
      e_ack = e_wr ? (4'b0001 << m_gid) : 4'b0000;
      chk("wr",   {31'd0, fifo_wr_req}, {31'd0, e_wr});
      chk("ack",  {28'd0, ack},         {28'd0, e_ack});
      chk("busy", {31'd0, busy},        {31'd0, m_busy});
      chk("gid",  {30'd0, grant_id},    32'(m_gid));
      if (e_wr) chk("data", {24'd0, fifo_data}, {24'd0, data_in[m_gid*DW +: DW]});
    end
  end

  // Burst log: one entry per grant with its number of acked words.
  int  burst_gid[$];
  int  burst_acks[$];
  logic prev_busy = 1'b0;
  always @(negedge clk) begin
    if (busy && !prev_busy) begin
      burst_gid.push_back(int'(grant_id));
      burst_acks.push_back(0);
    end
    if (fifo_wr_req && burst_acks.size() > 0)
      burst_acks[burst_acks.size()-1] = burst_acks[burst_acks.size()-1] + 1;
    prev_busy = busy;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    logic [9:0] pat;
    int exp_g[5];
    rst = 1'b0; req = '0; fifo_full = 1'b0;
    data_in = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
    exp_g = '{0, 1, 2, 3, 0};
    repeat (2) tick();
    chk("reset_gid",  {30'd0, grant_id}, 32'd0);
    chk("reset_busy", {31'd0, busy},     32'd0);
    chk("reset_wr",   {31'd0, fifo_wr_req}, 32'd0);

    // T1: single requester, two back-to-back bursts with one dead cycle.
    req = 4'b0001; rst = 1'b1; #1;
    chk("t1_first_idle", {31'd0, busy}, 32'd0);
    pat = '0;
    for (int i = 0; i < 10; i++) begin
      tick();
      pat = {pat[8:0], fifo_wr_req};
      if (fifo_wr_req) chk("t1_data", {24'd0, fifo_data}, 32'h0000_00A0);
    end
    chk("t1_pattern", {22'd0, pat}, {22'd0, 10'b1111011110});
    req = '0;

    // T2: all requesting after reset; grants 0,1,2,3,0 of 4 words each.
    rst = 1'b0; tick(); rst = 1'b1; req = 4'b1111;
    burst_gid.delete(); burst_acks.delete();
    repeat (25) tick();
    req = '0; tick();
    chk("t2_nbursts", 32'(burst_gid.size()), 32'd5);
    for (int i = 0; i < 5; i++) begin
      if (i < burst_gid.size()) begin
        chk("t2_grant", 32'(burst_gid[i]),  32'(exp_g[i]));
        chk("t2_acks",  32'(burst_acks[i]), 32'd4);
      end
    end

    // T3: requester 2 writes two words then withdraws; next search wraps to 0.
    req = 4'b0100;
    tick(); chk("t3_gid", {30'd0, grant_id}, 32'd2); chk("t3_w1", {31'd0, fifo_wr_req}, 32'd1);
    tick(); chk("t3_w2", {31'd0, fifo_wr_req}, 32'd1);
    tick(); req = '0; #1;
    chk("t3_nowrite", {31'd0, fifo_wr_req}, 32'd0);
    chk("t3_still_busy", {31'd0, busy}, 32'd1);
    tick(); chk("t3_exit", {31'd0, busy}, 32'd0);
    req = 4'b0011;
    tick(); chk("t3_wrap_gid", {30'd0, grant_id}, 32'd0);
    repeat (4) tick();
    chk("t3_burst_done", {31'd0, busy}, 32'd0);
    req = '0;

    // T4: five full cycles mid-burst; burst still totals exactly 4 writes.
    req = 4'b1000; pat = '0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (i == 3) fifo_full = 1'b1;
      if (i == 8) fifo_full = 1'b0;
      #1;
      pat = {pat[8:0], fifo_wr_req};
      if (fifo_wr_req) chk("t4_data", {24'd0, fifo_data}, 32'h0000_00D3);
    end
    chk("t4_pattern", {22'd0, pat}, {22'd0, 10'b1100000110});
    req = '0;

    // T5: reset mid-burst after two writes; requester 0 re-served with a full burst.
    req = 4'b0001;
    repeat (3) tick();
    rst = 1'b0; #1;
    chk("t5_wr_drop",  {31'd0, fifo_wr_req}, 32'd0);
    chk("t5_ack_drop", {28'd0, ack},         32'd0);
    chk("t5_busy",     {31'd0, busy},        32'd0);
    tick(); rst = 1'b1;
    pat = '0;
    for (int i = 0; i < 5; i++) begin
      tick();
      pat = {pat[8:0], fifo_wr_req};
    end
    chk("t5_pattern", {22'd0, pat}, {22'd0, 10'b0000011110});
    req = '0;

    // T6: full stall with two requesters.
    rst = 1'b0; tick(); rst = 1'b1; req = 4'b0011; fifo_full = 1'b1;
    repeat (12) tick();
`ifdef FIFO_ARB_TIMEOUT_EN
    chk("t6_gid", {30'd0, grant_id}, 32'd1);
`else
    chk("t6_gid", {30'd0, grant_id}, 32'd0);
`endif
    chk("t6_busy", {31'd0, busy}, 32'd1);
    fifo_full = 1'b0;
    repeat (12) tick();
    req = '0;
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
